seq_div64: RTL and testbench
============================

SEQ_DIV64 -- requirements
Module: seq_div64

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning divisor/quotient/remainder width; dividend width is 2N (verified at N=32 only).
REQ-002 The block SHALL have port clk, input, 1, the single clock; every flop SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the dividend and divisor are presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept an operand pair.
REQ-006 The block SHALL have port dividend, input, 2N, the unsigned dividend.
REQ-007 The block SHALL have port divisor, input, N, the unsigned divisor.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 The block SHALL have port quotient, output, N, the unsigned quotient.
REQ-011 The block SHALL have port remainder, output, N, the unsigned remainder.
REQ-012 The block SHALL have port div_zero, output, 1, flagging that the divisor was zero.
REQ-013 The block SHALL have port overflow, output, 1, flagging that the quotient does not fit in N bits.

Function
REQ-014 The block SHALL be the inverse of the team's 32x32->64 pipelined multiplier: for any product P=a*b with b!=0 it SHALL return quotient=a, remainder=0.
REQ-015 The FSM SHALL have exactly three states, IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; it SHALL register dividend and divisor and zero the iteration counter.
REQ-017 On accept with divisor=0, the FSM SHALL go IDLE->DONE with div_zero=1, overflow=0, quotient=all-ones, remainder=dividend[N-1:0].
REQ-018 On accept with divisor!=0 and dividend[2N-1:N]>=divisor, the FSM SHALL go IDLE->DONE with overflow=1, div_zero=0, quotient=all-ones, remainder=0.
REQ-019 Otherwise the FSM SHALL go IDLE->BUSY with partial remainder R(N+1 bits)=dividend[2N-1:N], shift register Q=dividend[N-1:0], counter=0.
REQ-020 BUSY SHALL use one restoring iteration per edge: T={R[N-1:0],Q[N-1]}; if T>=divisor then R=T-divisor and the new Q LSB is 1, else R=T and the new Q LSB is 0; Q shifts left by 1; the counter increments.
REQ-021 After the N-th BUSY iteration (counter reaching N-1 on that edge), the FSM SHALL enter DONE with quotient=Q, remainder=R[N-1:0], and both flags 0.
REQ-022 Normal latency SHALL be N+1 edges from the accept edge to out_valid high (33 at N=32); the div_zero and overflow latency SHALL be 1 edge.
REQ-023 In DONE, out_valid, quotient, remainder and flags SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-024 There SHALL be no back-to-back accept: an accept SHALL be possible no earlier than the edge after the result handshake.
REQ-025 in_valid in BUSY or DONE SHALL be ignored, and operand input changes after accept SHALL NOT affect the result.
REQ-026 In IDLE and BUSY, quotient, remainder and flags SHALL read 0.

Reset
REQ-027 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, the counter, R, Q, quotient, remainder, div_zero and overflow SHALL clear to 0, out_valid SHALL be 0, and in_ready SHALL be 0.
REQ-028 in_ready SHALL rise on the first edge with rst_n=1.
REQ-029 A reset in BUSY or DONE SHALL abandon the operation with no result emitted, and the next accept SHALL compute correctly from clean state.

Verification
REQ-030 Basic: dividend=100, divisor=7, out_ready=1 -> out_valid after 33 edges, quotient=14, remainder=2, flags 0, single-cycle out_valid.
REQ-031 Full-scale: dividend=64'hFFFFFFFE_00000001, divisor=32'hFFFFFFFF -> quotient=32'hFFFFFFFF, remainder=0, overflow=0.
REQ-032 Exceptions: divisor=0, dividend=64'h12345678_9ABCDEF0 -> 1-edge latency, div_zero=1, quotient=32'hFFFFFFFF, remainder=32'h9ABCDEF0; dividend=64'h00000001_00000000, divisor=1 -> overflow=1, quotient=32'hFFFFFFFF, remainder=0.
REQ-033 Backpressure: dividend=1000, divisor=33, out_ready held 0 for 5 cycles after out_valid -> outputs hold quotient=30, remainder=10 throughout, in_ready stays 0, and in_valid pulsed with other operands is ignored.
REQ-034 Reset mid-op: rst_n=0 for 1 edge at BUSY iteration 10 -> all outputs 0 and no out_valid, then dividend=49, divisor=7 -> quotient=7, remainder=0.
REQ-035 Round-trip: 1000 random (a,b) pairs with b!=0 fed through the multiplier, P=a*b -> quotient=a, remainder=0 for each; 1000 random dividend/divisor pairs checked against a reference model.

Source files
------------

// File: rtl/seq_div64.sv
// Sequential restoring divider: 2N-bit unsigned dividend by N-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient-overflow cases finish in one edge; other operands take N+1 edges.
module seq_div64 #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_zero,
   output logic           overflow
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  dvs_q;
   // Partial remainder is always below the divisor, so its top bit is dropped between iterations.
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N:0]    trial;
   logic          trial_ge;
   logic          in_ready_q, out_valid_q, div_zero_q, overflow_q;
   logic [N-1:0]  quotient_q, remainder_q;

   always_comb begin
      trial    = {rem_q, quo_q[N-1]};
      trial_ge = (trial >= {1'b0, dvs_q});
      rem_d    = trial_ge ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
      quo_d    = {quo_q[N-2:0], trial_ge};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  dvs_q      <= divisor;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  if (divisor == '0) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     div_zero_q  <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= dividend[N-1:0];
                  end else if (dividend[2*N-1:N] >= divisor) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     overflow_q  <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= '0;
                  end else begin
                     state_q <= BUSY;
                     rem_q   <= dividend[2*N-1:N];
                     quo_q   <= dividend[N-1:0];
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            BUSY: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  quotient_q  <= quo_d;
                  remainder_q <= rem_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  div_zero_q  <= 1'b0;
                  overflow_q  <= 1'b0;
                  quotient_q  <= '0;
                  remainder_q <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_div64.sv
// Self-checking bench for seq_div64: directed literal cases plus randomized traffic,
// with a per-cycle monitor comparing every output against an arithmetic reference model.
module tb_seq_div64;

   localparam int N = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   dividend;
   logic [31:0]   divisor;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   quotient;
   logic [31:0]   remainder;
   logic          div_zero;
   logic          overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
      int          acc;
   } exp_t;

   exp_t pend[$];
   exp_t mon_e;
   bit   head_seen = 0;

   seq_div64 #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [63:0] dvd, input logic [31:0] dvs);
      exp_t e;
      e.acc = 0;
      e.dz  = 1'b0;
      e.ov  = 1'b0;
      if (dvs == 32'd0) begin
         e.dz = 1'b1;
         e.q  = 32'hFFFF_FFFF;
         e.r  = dvd[31:0];
      end else if (dvd[63:32] >= dvs) begin
         e.ov = 1'b1;
         e.q  = 32'hFFFF_FFFF;
         e.r  = 32'd0;
      end else begin
         e.q = 32'(dvd / {32'd0, dvs});
         e.r = 32'(dvd % {32'd0, dvs});
      end
      return e;
   endfunction

   // Per-cycle compare against the model; outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend.delete();
         head_seen = 0;
      end else begin
         if (out_valid) begin
            check("in_ready_while_done", in_ready, 0);
            if (pend.size() == 0) begin
               check("spurious_out_valid", out_valid, 0);
            end else begin
               check("quotient", quotient, pend[0].q);
               check("remainder", remainder, pend[0].r);
               check("div_zero", div_zero, pend[0].dz);
               check("overflow", overflow, pend[0].ov);
               if (!head_seen)
                  check("latency", cyc - pend[0].acc + 1, (pend[0].dz || pend[0].ov) ? 1 : N + 1);
               head_seen = 1;
               if (out_ready) begin
                  void'(pend.pop_front());
                  head_seen = 0;
               end
            end
         end else begin
            check("outputs_zero_when_not_done", {quotient, remainder, div_zero, overflow}, 0);
            if (pend.size() != 0) check("in_ready_while_busy", in_ready, 0);
         end
         if (in_valid && in_ready) begin
            mon_e     = model(dividend, divisor);
            mon_e.acc = cyc + 1;
            pend.push_back(mon_e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [63:0] dvd, input logic [31:0] dvs, input int hold,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output logic ov, output int lat);
      int w = 0;
      while (!in_ready && w < 50) begin
         step();
         w++;
      end
      check("in_ready_timeout", in_ready, 1);
      in_valid  = 1'b1;
      dividend  = dvd;
      divisor   = dvs;
      out_ready = (hold == 0);
      step();
      in_valid = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      check("out_valid_timeout", out_valid, 1);
      q  = quotient;
      r  = remainder;
      dz = div_zero;
      ov = overflow;
      if (hold > 0) begin
         repeat (hold) begin
            in_valid = 1'b1;
            dividend = {$urandom, $urandom};
            divisor  = $urandom;
            step();
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      step();
      out_ready = 1'b0;
   endtask

   logic [31:0] q, r, a, b, hi;
   logic        dz, ov;
   int          lat;
   logic [63:0] p;
   bit          seen_valid;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) step();
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_outputs", {quotient, remainder, div_zero, overflow}, 0);
      rst_n = 1'b1;
      step();
      check("in_ready_after_reset", in_ready, 1);

      // Basic division with latency pinned by hand.
      do_op(64'd100, 32'd7, 0, q, r, dz, ov, lat);
      check("basic_q", q, 14);
      check("basic_r", r, 2);
      check("basic_flags", {dz, ov}, 0);
      check("basic_lat", lat, 33);
      check("basic_single_cycle_valid", out_valid, 0);

      do_op(64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 0, q, r, dz, ov, lat);
      check("full_q", q, 32'hFFFFFFFF);
      check("full_r", r, 0);
      check("full_ov", ov, 0);

      do_op(64'h12345678_9ABCDEF0, 32'd0, 0, q, r, dz, ov, lat);
      check("dz_flag", dz, 1);
      check("dz_q", q, 32'hFFFFFFFF);
      check("dz_r", r, 32'h9ABCDEF0);
      check("dz_lat", lat, 1);

      do_op(64'h00000001_00000000, 32'd1, 0, q, r, dz, ov, lat);
      check("ov_flag", {dz, ov}, 2'b01);
      check("ov_q", q, 32'hFFFFFFFF);
      check("ov_r", r, 0);
      check("ov_lat", lat, 1);

      // Backpressure: result must hold while out_ready is low and in_valid is pulsed.
      do_op(64'd1000, 32'd33, 5, q, r, dz, ov, lat);
      check("bp_q", q, 30);
      check("bp_r", r, 10);

      // Reset in the middle of BUSY: no result may appear afterwards.
      while (!in_ready) step();
      in_valid  = 1'b1;
      dividend  = 64'd123456789;
      divisor   = 32'd1000;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midreset_out_valid", out_valid, 0);
      check("midreset_in_ready", in_ready, 0);
      check("midreset_outputs", {quotient, remainder, div_zero, overflow}, 0);
      seen_valid = 0;
      repeat (40) begin
         step();
         if (out_valid) seen_valid = 1;
      end
      check("midreset_no_result", seen_valid, 0);
      out_ready = 1'b0;
      do_op(64'd49, 32'd7, 0, q, r, dz, ov, lat);
      check("post_reset_q", q, 7);
      check("post_reset_r", r, 0);

      // Round trip through the multiplier: (a*b)/b must give a exactly.
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         if (b == 32'd0) b = 32'd1;
         p = 64'(a) * 64'(b);
         do_op(p, b, 0, q, r, dz, ov, lat);
         check("roundtrip_q", q, a);
         check("roundtrip_r", r, 0);
      end

      // Random operands, checked by the monitor against the model.
      for (int i = 0; i < 1000; i++) begin
         int m;
         m = $urandom_range(0, 9);
         b = (m == 0) ? 32'd0 : $urandom;
         if (m == 1 || b == 32'd0) hi = $urandom;
         else                      hi = $urandom % b;
         do_op({hi, 32'($urandom)}, b, $urandom_range(0, 2), q, r, dz, ov, lat);
      end

      repeat (3) step();
      check("queue_drained", pend.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
